wb_stage: RTL and testbench

- Write-back stage directly downstream of the memory stage.
- Registers the MEM/WB pipeline boundary and owns the 32 x XLEN integer register file, including its write port and two bypassed read ports.
- Counts retired instructions and latches a sticky halt when a halt-flagged instruction retires.
- Decode reads operands from this block; hazard logic consumes wb_rd, wb_data and wb_reg_write for forwarding.

---
 rtl/wb_stage.sv | 136 +++++++++++++
 tb/tb_wb_stage.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB boundary register, 32-entry integer register file with
// write-through bypassed read ports, retired-instruction counter and sticky halt.
module wb_stage #(
    parameter int XLEN = 64,
    parameter int NREG = 32
) (
    input  logic            sys_clk,
    input  logic            sys_rst,
    input  logic            in_valid,
    input  logic            flush,
    input  logic [XLEN-1:0] mem_wb_data,
    input  logic [4:0]      mem_rd,
    input  logic            mem_reg_write,
    input  logic            mem_halt,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            wb_reg_write,
    output logic            halted,
    output logic [63:0]     retired_cnt
);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic              r_wb_valid;
    logic [4:0]        r_wb_rd;
    logic [XLEN-1:0]   r_wb_data;
    logic              r_wb_reg_write;
    logic              r_wb_halt;
    logic [63:0]       r_retired_cnt;
    logic [XLEN-1:0]   r_rf [NREG];

    logic              w_halt_retiring;
    logic              w_next_halted;
    logic              w_take;
    logic              w_rf_we;

    // Using the post-edge halt state here drops an instruction arriving on the
    // very edge where the halt retires.
    assign w_halt_retiring = r_wb_valid & r_wb_halt;
    assign w_next_halted   = (r_state == ST_HALTED) | w_halt_retiring;
    assign w_take          = in_valid & ~flush & ~w_next_halted;
    assign w_rf_we         = r_wb_reg_write & (r_wb_rd != 5'd0);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN:    if (w_halt_retiring) w_state_next = ST_HALTED;
            ST_HALTED: w_state_next = ST_HALTED;
            default:   w_state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_wb_valid     <= 1'b0;
            r_wb_rd        <= 5'd0;
            r_wb_data      <= '0;
            r_wb_reg_write <= 1'b0;
            r_wb_halt      <= 1'b0;
        end else begin
            r_wb_valid <= w_take;
            if (w_take) begin
                r_wb_rd        <= mem_rd;
                r_wb_data      <= mem_wb_data;
                r_wb_reg_write <= mem_reg_write;
                r_wb_halt      <= mem_halt;
            end else begin
                r_wb_reg_write <= 1'b0;
                r_wb_halt      <= 1'b0;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_retired_cnt <= 64'd0;
        end else if (r_wb_valid) begin
            r_retired_cnt <= r_retired_cnt + 64'd1;
        end
    end

    // Full clear on reset rules out a block-RAM mapping; the file lives in flops.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_rf[i] <= '0;
            end
        end else if (w_rf_we) begin
            r_rf[r_wb_rd] <= r_wb_data;
        end
    end

    always_comb begin
        rs1_data = r_rf[rs1_addr];
        if (rs1_addr == 5'd0) begin
            rs1_data = '0;
        end else if (r_wb_reg_write && (rs1_addr == r_wb_rd)) begin
            rs1_data = r_wb_data;
        end
    end

    always_comb begin
        rs2_data = r_rf[rs2_addr];
        if (rs2_addr == 5'd0) begin
            rs2_data = '0;
        end else if (r_wb_reg_write && (rs2_addr == r_wb_rd)) begin
            rs2_data = r_wb_data;
        end
    end

    assign wb_valid     = r_wb_valid;
    assign wb_rd        = r_wb_rd;
    assign wb_data      = r_wb_data;
    assign wb_reg_write = r_wb_reg_write;
    assign halted       = (r_state == ST_HALTED);
    assign retired_cnt  = r_retired_cnt;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: reset, bypass, x0, bubbles, back-to-back, halt, reset recovery.
module tb_wb_stage;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        in_valid;
    logic        flush;
    logic [63:0] mem_wb_data;
    logic [4:0]  mem_rd;
    logic        mem_reg_write;
    logic        mem_halt;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [63:0] rs1_data;
    logic [63:0] rs2_data;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic        wb_reg_write;
    logic        halted;
    logic [63:0] retired_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 sys_clk = ~sys_clk;

    wb_stage #(.XLEN(64), .NREG(32)) dut (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .in_valid      (in_valid),
        .flush         (flush),
        .mem_wb_data   (mem_wb_data),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .mem_halt      (mem_halt),
        .rs1_addr      (rs1_addr),
        .rs2_addr      (rs2_addr),
        .rs1_data      (rs1_data),
        .rs2_data      (rs2_data),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .wb_reg_write  (wb_reg_write),
        .halted        (halted),
        .retired_cnt   (retired_cnt)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic read_reg(input logic [4:0] a, input string tag, input logic [63:0] exp);
        rs1_addr = a;
        rs2_addr = a;
        #1;
        check_eq({tag, "_p1"}, rs1_data, exp);
        check_eq({tag, "_p2"}, rs2_data, exp);
    endtask

    task automatic present(input logic [4:0] rd, input logic [63:0] d, input logic rw, input logic h);
        in_valid      = 1'b1;
        mem_rd        = rd;
        mem_wb_data   = d;
        mem_reg_write = rw;
        mem_halt      = h;
    endtask

    initial begin
        sys_rst  = 1'b1;
        flush    = 1'b0;
        rs1_addr = 5'd0;
        rs2_addr = 5'd0;
        present(5'd5, 64'hAAAA, 1'b1, 1'b0);

        // 1: reset dominates a valid write presented at the input
        tick();
        tick();
        check_eq("rst_wb_valid", {63'd0, wb_valid}, 64'd0);
        check_eq("rst_wb_rw", {63'd0, wb_reg_write}, 64'd0);
        check_eq("rst_retired", retired_cnt, 64'd0);
        check_eq("rst_halted", {63'd0, halted}, 64'd0);
        for (int a = 0; a < 32; a++) begin
            rs1_addr = 5'(a);
            rs2_addr = 5'(31 - a);
            #1;
            check_eq($sformatf("rst_rs1_x%0d", a), rs1_data, 64'd0);
            check_eq($sformatf("rst_rs2_x%0d", 31 - a), rs2_data, 64'd0);
        end
        sys_rst  = 1'b0;
        in_valid = 1'b0;

        // 2: bypass in WB cycle, array read the cycle after
        present(5'd5, 64'hDEADBEEF00000001, 1'b1, 1'b0);
        tick();
        in_valid = 1'b0;
        check_eq("t2_wb_valid", {63'd0, wb_valid}, 64'd1);
        check_eq("t2_wb_rd", {59'd0, wb_rd}, 64'd5);
        check_eq("t2_retired0", retired_cnt, 64'd0);
        read_reg(5'd5, "t2_bypass", 64'hDEADBEEF00000001);
        tick();
        check_eq("t2_wb_valid_off", {63'd0, wb_valid}, 64'd0);
        read_reg(5'd5, "t2_array", 64'hDEADBEEF00000001);
        check_eq("t2_retired1", retired_cnt, 64'd1);

        // 3: write to x0 is counted but never visible
        present(5'd0, 64'h1234, 1'b1, 1'b0);
        read_reg(5'd0, "t3_x0_pre", 64'd0);
        tick();
        in_valid = 1'b0;
        check_eq("t3_wb_rw", {63'd0, wb_reg_write}, 64'd1);
        read_reg(5'd0, "t3_x0_wb", 64'd0);
        tick();
        read_reg(5'd0, "t3_x0_post", 64'd0);
        check_eq("t3_retired2", retired_cnt, 64'd2);

        // 4a: flush turns a valid instruction into a bubble
        present(5'd3, 64'h55, 1'b1, 1'b0);
        flush = 1'b1;
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
        check_eq("t4a_wb_valid", {63'd0, wb_valid}, 64'd0);
        check_eq("t4a_wb_rw", {63'd0, wb_reg_write}, 64'd0);
        read_reg(5'd3, "t4a_x3_wb", 64'd0);
        tick();
        read_reg(5'd3, "t4a_x3", 64'd0);
        check_eq("t4a_retired", retired_cnt, 64'd2);

        // 4b: in_valid low is a bubble regardless of payload
        present(5'd3, 64'h55, 1'b1, 1'b0);
        in_valid = 1'b0;
        tick();
        check_eq("t4b_wb_valid", {63'd0, wb_valid}, 64'd0);
        tick();
        read_reg(5'd3, "t4b_x3", 64'd0);
        check_eq("t4b_retired", retired_cnt, 64'd2);

        // 5: back-to-back writes to x4, both ports follow the newest value
        present(5'd4, 64'd1, 1'b1, 1'b0);
        tick();
        present(5'd4, 64'd2, 1'b1, 1'b0);
        read_reg(5'd4, "t5_n1", 64'd1);
        tick();
        in_valid = 1'b0;
        read_reg(5'd4, "t5_n2", 64'd2);
        tick();
        read_reg(5'd4, "t5_final", 64'd2);
        check_eq("t5_retired", retired_cnt, 64'd4);

        // 6: A, B(halt), C back-to-back; C must be dropped
        present(5'd1, 64'd9, 1'b1, 1'b0);
        tick();
        present(5'd2, 64'd7, 1'b1, 1'b1);
        tick();
        present(5'd3, 64'd8, 1'b1, 1'b0);
        check_eq("t6_not_halted_yet", {63'd0, halted}, 64'd0);
        check_eq("t6_wb_rd_b", {59'd0, wb_rd}, 64'd2);
        tick();
        check_eq("t6_halted", {63'd0, halted}, 64'd1);
        check_eq("t6_c_dropped", {63'd0, wb_valid}, 64'd0);
        check_eq("t6_retired", retired_cnt, 64'd6);
        read_reg(5'd1, "t6_x1", 64'd9);
        read_reg(5'd2, "t6_x2", 64'd7);
        read_reg(5'd3, "t6_x3", 64'd0);
        for (int k = 0; k < 4; k++) begin
            present(5'd6, 64'h66 + 64'(k), 1'b1, 1'b0);
            flush = k[0];
            tick();
            check_eq($sformatf("t6_frozen_valid_%0d", k), {63'd0, wb_valid}, 64'd0);
            check_eq($sformatf("t6_frozen_cnt_%0d", k), retired_cnt, 64'd6);
        end
        in_valid = 1'b0;
        flush    = 1'b0;
        tick();
        read_reg(5'd6, "t6_x6", 64'd0);
        check_eq("t6_still_halted", {63'd0, halted}, 64'd1);

        // Reset recovery, then reset while an instruction sits in WB
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        check_eq("rr_halted", {63'd0, halted}, 64'd0);
        check_eq("rr_retired", retired_cnt, 64'd0);
        read_reg(5'd1, "rr_x1", 64'd0);
        present(5'd7, 64'h77, 1'b1, 1'b0);
        tick();
        in_valid = 1'b0;
        check_eq("mid_wb_valid", {63'd0, wb_valid}, 64'd1);
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        tick();
        read_reg(5'd7, "mid_x7", 64'd0);
        check_eq("mid_retired", retired_cnt, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
